// File: rtl/vrf_bram_rd_ctrl.sv
// Burst read controller for a VRF BRAM port: issues one read per cycle, tracks the
// fixed read latency and returns words on a valid/ready stream through a credit-guarded FIFO.
module vrf_bram_rd_ctrl #(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 2048,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [LEN_W-1:0]         req_len,
    output logic                     bram_en,
    output logic [$clog2(DEPTH)-1:0] bram_addr,
    output logic                     bram_oreg_en,
    output logic                     bram_rst,
    input  logic [WIDTH-1:0]         bram_dout,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_last,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   FD       = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FD_C     = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     cur_addr, cur_addr_nx;
    logic [LEN_W-1:0]  remaining, remaining_nx;
    logic              issue, issue_last, push, push_last, pop, credit_ok;
    logic [CW-1:0]     fifo_count, inflight_count;
    logic [CW:0]       occupancy;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];

    assign pop        = m_valid && m_ready;
    assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight_count};
    // A pop in this cycle frees its slot in time for a word issued now.
    assign credit_ok  = occupancy < (FD + (CW + 1)'(pop));
    assign issue_last = (remaining == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nx;
            cur_addr  <= cur_addr_nx;
            remaining <= remaining_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cur_addr_nx  = cur_addr;
        remaining_nx = remaining;
        issue        = 1'b0;
        req_ready    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    cur_addr_nx  = req_addr;
                    remaining_nx = req_len;
                    state_nx     = ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok && !rst) begin
                    issue        = 1'b1;
                    cur_addr_nx  = (cur_addr == ADDR_MAX) ? '0 : cur_addr + AW'(1);
                    remaining_nx = remaining - LEN_W'(1);
                    if (issue_last) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bram_en      = issue;
    assign bram_addr    = cur_addr;
    assign bram_oreg_en = 1'b1;
    assign bram_rst     = rst;

    // The word is on bram_dout RD_LATENCY-1 cycles after issue; latency 1 captures in the issue cycle.
    generate
        if (RD_LATENCY <= 1) begin : g_lat1
            assign push           = issue;
            assign push_last      = issue && issue_last;
            assign inflight_count = '0;
        end else begin : g_pipe
            localparam int NS = RD_LATENCY - 1;
            logic [NS-1:0] pv, pl;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                    pl <= '0;
                end else begin
                    pv[0] <= issue;
                    pl[0] <= issue && issue_last;
                    for (int unsigned i = 1; i < NS; i++) begin
                        pv[i] <= pv[i-1];
                        pl[i] <= pl[i-1];
                    end
                end
            end

            assign push      = pv[NS-1];
            assign push_last = pl[NS-1];

            always_comb begin
                inflight_count = '0;
                for (int unsigned i = 0; i < NS; i++)
                    inflight_count = inflight_count + CW'(pv[i]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bram_dout;
            fifo_last[wr_ptr] <= push_last;
        end
    end

    assign m_valid = (fifo_count != '0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = m_valid && fifo_last[rd_ptr];
    assign busy    = (state != IDLE) || (inflight_count != '0) || (fifo_count != '0);

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && fifo_count == FD_C));

endmodule

// File: tb/tb_vrf_bram_rd_ctrl.sv
// Scoreboard bench: two controllers (read latency 2 and 1) driven with the same bursts,
// each checked against an arithmetic burst model by an independent output monitor.
module tb_vrf_bram_rd_ctrl;
    localparam int WIDTH      = 128;
    localparam int DEPTH      = 2048;
    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W      = 8;
    localparam int AW         = $clog2(DEPTH);

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid [2];
    logic             req_ready [2];
    logic [AW-1:0]    req_addr;
    logic [LEN_W-1:0] req_len;
    logic             bram_en [2];
    logic [AW-1:0]    bram_addr [2];
    logic             bram_oreg_en [2];
    logic             bram_rst [2];
    logic [WIDTH-1:0] bram_dout [2];
    logic             m_valid [2];
    logic [WIDTH-1:0] m_data [2];
    logic             m_last [2];
    logic             busy [2];
    logic             m_ready, m_ready_dir, rnd_mode, rnd_bit;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    addr_q0;

    exp_t             exp_q [2][$];
    int               n_cmp = 0, n_bad = 0, cyc = 0;
    int               acc [2];
    int               lasts [2];
    bit               seen_rb [2];
    bit               prev_stall [2];
    logic [WIDTH-1:0] prev_data [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign m_ready = rnd_mode ? rnd_bit : m_ready_dir;
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // BRAM models: data for an issue in cycle t is presented in cycle t+RD_LATENCY-1.
    always @(posedge clk) addr_q0 <= bram_addr[0];
    assign bram_dout[0] = mem[addr_q0];
    assign bram_dout[1] = mem[bram_addr[1]];

    vrf_bram_rd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(2),
                       .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) u_dut_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_len(req_len), .bram_en(bram_en[0]),
        .bram_addr(bram_addr[0]), .bram_oreg_en(bram_oreg_en[0]), .bram_rst(bram_rst[0]),
        .bram_dout(bram_dout[0]), .m_valid(m_valid[0]), .m_ready(m_ready),
        .m_data(m_data[0]), .m_last(m_last[0]), .busy(busy[0]));

    vrf_bram_rd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(1),
                       .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) u_dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_len(req_len), .bram_en(bram_en[1]),
        .bram_addr(bram_addr[1]), .bram_oreg_en(bram_oreg_en[1]), .bram_rst(bram_rst[1]),
        .bram_dout(bram_dout[1]), .m_valid(m_valid[1]), .m_ready(m_ready),
        .m_data(m_data[1]), .m_last(m_last[1]), .busy(busy[1]));

    task automatic check(input string name, input int d, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    // Output monitor: pops the expected stream on every accepted word.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                prev_stall[d] = 1'b0;
            end else begin
                if (req_ready[d] && busy[d]) seen_rb[d] = 1'b1;
                if (prev_stall[d] && m_valid[d]) check("stall_hold", d, m_data[d], prev_data[d]);
                if (m_valid[d] && m_ready) begin
                    if (m_last[d]) lasts[d]++;
                    if (exp_q[d].size() == 0) begin
                        check("unexpected_word", d, m_data[d], {WIDTH{1'b1}} ^ m_data[d]);
                    end else begin
                        exp_t e;
                        e = exp_q[d].pop_front();
                        check("data", d, m_data[d], e.data);
                        check("last", d, WIDTH'(m_last[d]), WIDTH'(e.last));
                    end
                end
                prev_stall[d] = m_valid[d] && !m_ready;
                prev_data[d]  = m_data[d];
            end
        end
    end

    task automatic send(input logic [AW-1:0] addr, input logic [LEN_W-1:0] len);
        bit hs [2];
        int t;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k <= int'(len); k++)
                exp_q[d].push_back({k == int'(len), WIDTH'((int'(addr) + k) % DEPTH)});
            req_valid[d] = 1'b1;
        end
        req_addr = addr;
        req_len  = len;
        t = 0;
        while ((req_valid[0] || req_valid[1]) && t < 300) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                hs[d] = req_valid[d] && req_ready[d];
                if (hs[d]) acc[d] = cyc;
            end
            @(posedge clk);
            #1;
            t++;
            for (int d = 0; d < 2; d++) if (hs[d]) req_valid[d] = 1'b0;
        end
        if (t >= 300) begin
            check("req_accept_timeout", 0, WIDTH'(t), 0);
            req_valid[0] = 1'b0;
            req_valid[1] = 1'b0;
        end
    endtask

    task automatic wait_drain;
        int t = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || busy[0] || busy[1]) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 0, WIDTH'(t >= 1000), 0);
    endtask

    task automatic set_ready(input logic r, input logic rnd);
        @(posedge clk);
        #1;
        m_ready_dir = r;
        rnd_mode    = rnd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first [2];
        int nv [2];
        int cnt [2];
        int t;

        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
        rst = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_addr = '0;
        req_len = '0;
        m_ready_dir = 1'b1;
        rnd_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("ready_in_rst", d, WIDTH'(req_ready[d]), 0);
            check("bram_rst_in_rst", d, WIDTH'(bram_rst[d]), 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", d, WIDTH'(req_ready[d]), 1);
            check("rst_m_valid", d, WIDTH'(m_valid[d]), 0);
            check("rst_m_last", d, WIDTH'(m_last[d]), 0);
            check("rst_busy", d, WIDTH'(busy[d]), 0);
            check("rst_bram_en", d, WIDTH'(bram_en[d]), 0);
            check("rst_bram_addr", d, WIDTH'(bram_addr[d]), 0);
            check("oreg_en", d, WIDTH'(bram_oreg_en[d]), 1);
            check("bram_rst", d, WIDTH'(bram_rst[d]), 0);
        end

        // Basic burst with latency and back-to-back output timing.
        lasts = '{0, 0};
        send(AW'(16), LEN_W'(3));
        first = '{-1, -1};
        nv = '{0, 0};
        repeat (20) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (m_valid[d]) begin
                if (first[d] < 0) first[d] = cyc;
                if (cyc <= first[d] + 3) nv[d]++;
            end
        end
        check("first_latency", 0, WIDTH'(first[0] - acc[0]), 3);
        check("first_latency", 1, WIDTH'(first[1] - acc[1]), 2);
        for (int d = 0; d < 2; d++) check("consecutive", d, WIDTH'(nv[d]), 4);
        wait_drain();
        for (int d = 0; d < 2; d++) check("lasts_basic", d, WIDTH'(lasts[d]), 1);

        // Address wrap.
        lasts = '{0, 0};
        send(AW'(DEPTH - 2), LEN_W'(3));
        wait_drain();
        for (int d = 0; d < 2; d++) check("lasts_wrap", d, WIDTH'(lasts[d]), 1);

        // Backpressure: issue stops once FIFO plus in-flight words fill the buffer.
        lasts = '{0, 0};
        set_ready(1'b0, 1'b0);
        send(AW'(256), LEN_W'(15));
        cnt = '{0, 0};
        repeat (30) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (bram_en[d]) cnt[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            check("bp_issue_count", d, WIDTH'(cnt[d]), FIFO_DEPTH);
            check("bp_m_valid", d, WIDTH'(m_valid[d]), 1);
            check("bp_head", d, m_data[d], 256);
        end
        set_ready(1'b1, 1'b0);
        wait_drain();
        for (int d = 0; d < 2; d++) check("lasts_bp", d, WIDTH'(lasts[d]), 1);

        // Random backpressure over back-to-back bursts, then random bursts.
        lasts = '{0, 0};
        seen_rb = '{1'b0, 1'b0};
        set_ready(1'b0, 1'b1);
        send(AW'($urandom_range(0, DEPTH - 1)), LEN_W'(0));
        send(AW'($urandom_range(0, DEPTH - 1)), LEN_W'(7));
        send(AW'($urandom_range(0, DEPTH - 1)), LEN_W'(2));
        wait_drain();
        for (int d = 0; d < 2; d++) begin
            check("lasts_rand3", d, WIDTH'(lasts[d]), 3);
            check("ready_while_draining", d, WIDTH'(seen_rb[d]), 1);
        end
        lasts = '{0, 0};
        for (int i = 0; i < 6; i++)
            send(AW'($urandom_range(0, DEPTH - 1)), LEN_W'($urandom_range(0, 20)));
        wait_drain();
        for (int d = 0; d < 2; d++) check("lasts_rand6", d, WIDTH'(lasts[d]), 6);
        set_ready(1'b1, 1'b0);

        // Reset one cycle after the second issue of a burst.
        send(AW'(512), LEN_W'(9));
        t = 0;
        cnt[0] = 0;
        while (cnt[0] < 2 && t < 50) begin
            @(negedge clk);
            t++;
            if (bram_en[0]) cnt[0]++;
        end
        check("second_issue_seen", 0, WIDTH'(cnt[0]), 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("midrst_m_valid", d, WIDTH'(m_valid[d]), 0);
            check("midrst_busy", d, WIDTH'(busy[d]), 0);
            check("midrst_req_ready", d, WIDTH'(req_ready[d]), 1);
        end
        lasts = '{0, 0};
        send(AW'(5), LEN_W'(0));
        wait_drain();
        for (int d = 0; d < 2; d++) check("lasts_after_rst", d, WIDTH'(lasts[d]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
